// File: rtl/func_param.sv
// Multi-cycle evaluator: y = a^3 + isqrt(b) or a^2 + isqrt(b).
// One shared shift-add multiplier plus a concurrent restoring isqrt.
module func_param #(
  parameter int W = 8,
  localparam int YW = 3*W+1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [W-1:0]  a_bi,
  input  logic [W-1:0]  b_bi,
  output logic          busy_o,
  output logic          done_o,
  output logic [YW-1:0] y_bo
);

  localparam int PW = 3*W;
  localparam int CW = $clog2(W);
  localparam int SW = W/2;
  localparam int RW = W+2;
  localparam int QW = $clog2(SW+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL1 = 2'd1;
  localparam logic [1:0] MUL2 = 2'd2;
  localparam logic [1:0] ADD  = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(W-1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic          mode_q;
  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [PW-1:0] acc;
  logic [YW-1:0] y_q;

  logic [W-1:0]  sq_b;
  logic [RW-1:0] sq_rem;
  logic [SW-1:0] sq_root;
  logic [QW-1:0] sq_cnt;

  logic [PW-1:0] acc_nxt;
  logic          last;
  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;
  logic          ge;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    last    = (cnt == LAST);
    rem_sh  = (sq_rem << 2) | RW'(sq_b[W-1:W-2]);
    trial   = {{(RW-SW-2){1'b0}}, sq_root, 2'b01};
    ge      = (rem_sh >= trial);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      mode_q  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      y_q     <= '0;
      sq_b    <= '0;
      sq_rem  <= '0;
      sq_root <= '0;
      sq_cnt  <= '0;
    end else begin
      // root digit per cycle; idles once the count drains
      if (sq_cnt != '0) begin
        sq_b    <= sq_b << 2;
        sq_rem  <= ge ? rem_sh - trial : rem_sh;
        sq_root <= {sq_root[SW-2:0], ge};
        sq_cnt  <= sq_cnt - QW'(1);
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= MUL1;
            a_q     <= a_bi;
            mode_q  <= mode_i;
            mcand   <= PW'(a_bi);
            mplier  <= a_bi;
            acc     <= '0;
            cnt     <= '0;
            sq_b    <= b_bi;
            sq_rem  <= '0;
            sq_root <= '0;
            sq_cnt  <= QW'(SW);
          end
        end
        MUL1: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            cnt <= '0;
            if (!mode_q) begin
              // square becomes the multiplicand for the cube pass
              state  <= MUL2;
              mcand  <= acc_nxt;
              mplier <= a_q;
              acc    <= '0;
            end else begin
              state <= ADD;
            end
          end
        end
        MUL2: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          y_q   <= YW'(acc) + YW'(sq_root);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == ADD);
  assign y_bo   = y_q;

endmodule

// File: tb/tb_func_param.sv
// Scoreboard bench for func_param at W=8 and W=16.
// Directed vectors; monitors pop expectations on each done pulse.
module tb_func_param;

  typedef struct {
    logic [63:0] y;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, mode8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [24:0] y8;
  logic        start16, mode16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [48:0] y16;

  func_param #(.W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8),
    .mode_i(mode8), .a_bi(a8), .b_bi(b8),
    .busy_o(busy8), .done_o(done8), .y_bo(y8)
  );

  func_param #(.W(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16),
    .mode_i(mode16), .a_bi(a16), .b_bi(b16),
    .busy_o(busy16), .done_o(done16), .y_bo(y16)
  );

  exp_t        q8[$];
  exp_t        q16[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last8 = '0;
  logic [63:0] last16 = '0;
  int          cyc = 0;
  int          prev_done = -1;
  logic        b2b = 1'b0;
  logic        hold_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               n, act, exp, $time);
    end
  endtask

  // y must hold its last completed value between done pulses
  always @(negedge clk) begin
    if (hold_en && rst_n) begin
      chk("y8_hold", 64'(y8), last8);
      chk("y16_hold", 64'(y16), last16);
    end
  end

  initial begin
    int   bc;
    exp_t e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
      end else begin
        if (busy8) bc++;
        else bc = 0;
        if (done8) begin
          if (b2b && prev_done >= 0)
            chk("b2b_gap", 64'(cyc - prev_done), 64'd18);
          prev_done = cyc;
          if (q8.size() == 0) begin
            chk("done8_unexpected", 64'd1, 64'd0);
          end else begin
            e = q8.pop_front();
            chk("busy8_len", 64'(bc), 64'(e.lat));
            @(posedge clk);
            #1;
            chk("y8", 64'(y8), e.y);
            last8 = e.y;
          end
        end
      end
    end
  end

  initial begin
    int   bc;
    exp_t e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
      end else begin
        if (busy16) bc++;
        else bc = 0;
        if (done16) begin
          if (q16.size() == 0) begin
            chk("done16_unexpected", 64'd1, 64'd0);
          end else begin
            e = q16.pop_front();
            chk("busy16_len", 64'(bc), 64'(e.lat));
            @(posedge clk);
            #1;
            chk("y16", 64'(y16), e.y);
            last16 = e.y;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy8 && !busy16) return;
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic push,
                        input logic [63:0] y);
    exp_t e;
    @(negedge clk);
    a8 = a;
    b8 = b;
    mode8 = m;
    start8 = 1'b1;
    if (push) begin
      e.y = y;
      e.lat = m ? 9 : 17;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start8 = 1'b0;
    mode8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start16 = 1'b0;
    mode16 = 1'b0;
    a16 = '0;
    b16 = '0;
    #12;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_y8", 64'(y8), 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_y16", 64'(y16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_en = 1'b1;

    issue8(8'd2, 8'd10, 1'b0, 1'b1, 64'd11);
    wait_idle();
    issue8(8'd255, 8'd255, 1'b0, 1'b1, 64'd16581390);
    wait_idle();
    issue8(8'd255, 8'd255, 1'b1, 1'b1, 64'd65040);
    wait_idle();
    issue8(8'd0, 8'd0, 1'b0, 1'b1, 64'd0);
    wait_idle();
    issue8(8'd1, 8'd1, 1'b0, 1'b1, 64'd2);
    wait_idle();
    issue8(8'd3, 8'd16, 1'b1, 1'b1, 64'd13);
    wait_idle();
    issue8(8'd7, 8'd99, 1'b0, 1'b1, 64'd352);
    wait_idle();

    @(negedge clk);
    a16 = 16'hFFFF;
    b16 = 16'hFFFF;
    mode16 = 1'b0;
    start16 = 1'b1;
    e.y = 64'd281462092005630;
    e.lat = 33;
    q16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'd3;
    wait_idle();

    // second start while busy must not be taken
    issue8(8'd43, 8'd11, 1'b0, 1'b1, 64'd79510);
    repeat (3) @(negedge clk);
    a8 = 8'd2;
    b8 = 8'd10;
    mode8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'd200;
    b8 = 8'd77;
    wait_idle();

    issue8(8'd54, 8'd11, 1'b0, 1'b0, 64'd0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    last8 = '0;
    last16 = '0;
    #1;
    chk("abort_busy8", 64'(busy8), 64'd0);
    chk("abort_done8", 64'(done8), 64'd0);
    chk("abort_y8", 64'(y8), 64'd0);
    chk("abort_y16", 64'(y16), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue8(8'd54, 8'd11, 1'b0, 1'b1, 64'd157467);
    wait_idle();

    @(negedge clk);
    a8 = 8'd5;
    b8 = 8'd30;
    mode8 = 1'b0;
    start8 = 1'b1;
    e.y = 64'd130;
    e.lat = 17;
    for (int i = 0; i < 3; i++) q8.push_back(e);
    prev_done = -1;
    b2b = 1'b1;
    repeat (40) @(negedge clk);
    start8 = 1'b0;
    wait_idle();
    b2b = 1'b0;

    repeat (5) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
